// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and deglitched pins, 11-bit frame checker,
// and a first-word-fall-through byte FIFO with sticky overflow.
module ps2_rx_fifo #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 5000,
   parameter int unsigned ADDR_W      = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              PS2_CLK,
   input  logic              PS2_DATA,
   input  logic              iRead,
   input  logic              iClearErr,
   output logic [7:0]        oData,
   output logic              oValid,
   output logic [ADDR_W:0]   oCount,
   output logic              oOverflow,
   output logic              oParityErr,
   output logic              oFrameErr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned FC_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

   logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic              filt_q, filt_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic              strobe_q, strobe_d;
   logic              sbit_q, sbit_d;

   state_e            state_q, state_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [7:0]        sr_q, sr_d;
   logic              perr_q, perr_d;
   logic [TO_W-1:0]   tocnt_q, tocnt_d;
   logic              push_q, push_d;
   logic [7:0]        push_byte_q, push_byte_d;
   logic              perr_pulse_q, perr_pulse_d;
   logic              ferr_pulse_q, ferr_pulse_d;

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              valid_q, valid_d;
   logic [7:0]        data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              pop_c, full_c, push_eff_c, ovf_evt_c;

   // Synchroniser, clock filter and falling-edge strobe
   always_comb begin
      clk_s1_d = PS2_CLK;
      clk_s2_d = clk_s1_q;
      dat_s1_d = PS2_DATA;
      dat_s2_d = dat_s1_q;
      filt_d   = filt_q;
      fcnt_d   = '0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FC_W'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else                                  fcnt_d = fcnt_q + FC_W'(1);
      end
      strobe_d = filt_q & ~filt_d;
      sbit_d   = strobe_d ? dat_s2_q : sbit_q;
   end

   // Frame FSM: advances on strobes, aborts after TIMEOUT_CYC quiet cycles mid-frame
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      sr_d         = sr_q;
      perr_d       = perr_q;
      tocnt_d      = '0;
      push_d       = 1'b0;
      push_byte_d  = push_byte_q;
      perr_pulse_d = 1'b0;
      ferr_pulse_d = 1'b0;
      if (strobe_q) begin
         unique case (state_q)
            S_IDLE: begin
               if (!sbit_q) begin
                  state_d  = S_DATA;
                  bitcnt_d = '0;
               end
            end
            S_DATA: begin
               sr_d     = {sbit_q, sr_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               perr_d  = ~^{sr_q, sbit_q};
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (!sbit_q)     ferr_pulse_d = 1'b1;
               else if (perr_q) perr_pulse_d = 1'b1;
               else begin
                  push_d      = 1'b1;
                  push_byte_d = sr_q;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         if (tocnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d      = S_IDLE;
            ferr_pulse_d = 1'b1;
            bitcnt_d     = '0;
            sr_d         = '0;
         end else begin
            tocnt_d = tocnt_q + TO_W'(1);
         end
      end
   end

   // FWFT FIFO: head byte and flags registered, head forwarded when written this cycle
   always_comb begin
      pop_c      = iRead & valid_q;
      full_c     = (count_q == CNT_W'(DEPTH));
      push_eff_c = push_q & (~full_c | pop_c);
      ovf_evt_c  = push_q & full_c & ~pop_c;
      wr_ptr_d   = push_eff_c ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop_c ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push_eff_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_eff_c) count_d = count_q - CNT_W'(1);
      valid_d = (count_d != '0);
      if (push_eff_c && (wr_ptr_q == rd_ptr_d)) data_d = push_byte_q;
      else                                      data_d = mem_q[rd_ptr_d];
      if (ovf_evt_c)      ovf_d = 1'b1;
      else if (iClearErr) ovf_d = 1'b0;
      else                ovf_d = ovf_q;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         clk_s1_q     <= 1'b1;
         clk_s2_q     <= 1'b1;
         dat_s1_q     <= 1'b1;
         dat_s2_q     <= 1'b1;
         filt_q       <= 1'b1;
         fcnt_q       <= '0;
         strobe_q     <= 1'b0;
         sbit_q       <= 1'b1;
         state_q      <= S_IDLE;
         bitcnt_q     <= '0;
         sr_q         <= '0;
         perr_q       <= 1'b0;
         tocnt_q      <= '0;
         push_q       <= 1'b0;
         push_byte_q  <= '0;
         perr_pulse_q <= 1'b0;
         ferr_pulse_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         ovf_q        <= 1'b0;
      end else begin
         clk_s1_q     <= clk_s1_d;
         clk_s2_q     <= clk_s2_d;
         dat_s1_q     <= dat_s1_d;
         dat_s2_q     <= dat_s2_d;
         filt_q       <= filt_d;
         fcnt_q       <= fcnt_d;
         strobe_q     <= strobe_d;
         sbit_q       <= sbit_d;
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         sr_q         <= sr_d;
         perr_q       <= perr_d;
         tocnt_q      <= tocnt_d;
         push_q       <= push_d;
         push_byte_q  <= push_byte_d;
         perr_pulse_q <= perr_pulse_d;
         ferr_pulse_q <= ferr_pulse_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         ovf_q        <= ovf_d;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push_eff_c) begin
         mem_q[wr_ptr_q] <= push_byte_q;
      end
   end

   assign oData      = data_q;
   assign oValid     = valid_q;
   assign oCount     = count_q;
   assign oOverflow  = ovf_q;
   assign oParityErr = perr_pulse_q;
   assign oFrameErr  = ferr_pulse_q;

endmodule
